slave_in_port: RTL
==================

Name: slave_in_port

Overview:
- Slave-side receiver for the serial system bus; the counterpart of the master transmit port.
- Recognises its slave_select code and answers master_valid with slave_ready.
- Deserialises the 1-bit address, burst-count and data lines.
- Writes: issues one local-memory write per beat. Reads: hands the latched address and burst to the sibling slave read-return block and signals completion with rx_done.

Parameters:
- SLAVE_ID, 2'b00, slave_select code this instance answers to.
- ADDR_WIDTH, 12, address bits, shifted LSB first.
- DATA_WIDTH, 8, data bits per beat, shifted LSB first.
- BURST_WIDTH, 12, burst-count bits; beats = burst_num+1.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- slave_select  in  2  target code driven by the master.
- master_valid  in  1  master has a valid bit on the serial lines.
- write_en  in  1  transaction is a write.
- read_en  in  1  transaction is a read.
- rx_address  in  1  serial address line.
- rx_burst_number  in  1  serial burst-count line.
- rx_data  in  1  serial write-data line.
- read_done  in  1  sibling read-return block finished the read.
- slave_ready  out  1  slave accepts bits.
- rx_done  out  1  one-cycle transaction-complete pulse.
- mem_wr_en  out  1  one-cycle local write strobe.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_wdata  out  DATA_WIDTH  write data.
- read_req  out  1  one-cycle read hand-off pulse.
- read_addr  out  ADDR_WIDTH  latched read start address.
- read_burst  out  BURST_WIDTH  latched read burst count.

Behaviour:
- Reset (reset=0, async):
  - All outputs 0.
  - FSM to IDLE; shift registers and counters cleared.
  - Applies mid-transaction; no partial write is issued.
- Bit acceptance: a bit is sampled on a rising edge only when master_valid=1 and slave_ready=1.
  - master_valid low mid-phase stalls; shift registers and counters hold.
- FSM states: IDLE, ADDR, DATA, WSTROBE, RDREQ, RDWAIT, DONE.
- IDLE:
  - Leave only when master_valid=1, slave_select==SLAVE_ID, and exactly one of write_en/read_en is 1.
  - write_en=read_en=1 or both 0: stay IDLE, slave_ready stays 0.
  - On entry to ADDR: latch direction; slave_ready=1 next cycle.
- ADDR:
  - Shift rx_address and rx_burst_number in parallel for max(ADDR_WIDTH,BURST_WIDTH)=12 accepted bits.
  - Then go to DATA (write) or RDREQ (read).
- DATA:
  - Shift DATA_WIDTH accepted bits of rx_data.
  - After the 8th bit, go to WSTROBE.
- WSTROBE:
  - Single cycle; slave_ready=0.
  - mem_wr_en=1, mem_addr=base+beat (mod 2^ADDR_WIDTH, wraps 0xFFF->0x000), mem_wdata=assembled byte.
  - If beat==burst: go to DONE. Else beat++, return to DATA (slave_ready=1 again).
- RDREQ:
  - One cycle: read_req=1, read_addr and read_burst driven from latches; slave_ready=0.
  - Then RDWAIT.
- RDWAIT: hold until read_done=1, then DONE.
  - read_done while not in RDWAIT is ignored.
- DONE: rx_done=1 for one cycle, slave_ready=0, then IDLE.
- Latency, single-beat write with no stalls: 12 address cycles + 8 data cycles, mem_wr_en on the next cycle, rx_done one cycle after mem_wr_en.
- Burst counter is BURST_WIDTH wide; burst=4095 gives 4096 beats with no overflow of the beat counter compare.
- slave_select changing mid-transaction is ignored once out of IDLE.

Decomposition:
- Shared bus package holds:
  - ADDR_WIDTH, DATA_WIDTH and BURST_WIDTH constants.
  - Slave-select codes.
  - FSM state encoding.
- One natural sub-module, serial_shift_in: parameterised width, LSB-first shift register with a bit counter and a full flag. Instantiated for address, burst and data.

Test Plan:
- Single write: slave_select=2'b00, write_en=1, addr=12'h553, burst=0, data=8'h09, master_valid held -> one mem_wr_en with mem_addr=0x553, mem_wdata=0x09 on cycle 21 after acceptance; rx_done on the next cycle.
- Burst write: addr=12'h553, burst=2, data 0x11/0x22/0x33 -> three mem_wr_en pulses at 0x553/0x554/0x555 with matching data; one rx_done.
- Wrap and stall: addr=12'hFFF, burst=1, master_valid low for 3 cycles mid-beat 0 -> writes at 0xFFF then 0x000 with correct data; completion delayed by exactly 3 cycles.
- Read hand-off: read_en=1, addr=12'h010, burst=3 -> read_req pulse with read_addr=0x010, read_burst=3; no rx_done until read_done is pulsed, then rx_done on the next cycle.
- Non-selection and illegal ops: slave_select=2'b10 with SLAVE_ID=0, then write_en=read_en=1 -> slave_ready, mem_wr_en and rx_done stay 0.
- Reset mid-burst: drop reset during beat 1 of a burst-2 write -> all outputs 0 immediately, no further mem_wr_en. After release, a fresh single write completes normally.

Source files
------------

// File: rtl/slave_in_port_pkg.sv
// Shared definitions for the serial system bus slave receive path:
// bus widths, slave-select codes and the receiver FSM encoding.
package slave_in_port_pkg;

  localparam int BUS_ADDR_WIDTH  = 12;
  localparam int BUS_DATA_WIDTH  = 8;
  localparam int BUS_BURST_WIDTH = 12;

  typedef enum logic [1:0] {
    SEL_SLAVE0 = 2'b00,
    SEL_SLAVE1 = 2'b01,
    SEL_SLAVE2 = 2'b10,
    SEL_SLAVE3 = 2'b11
  } slave_sel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WSTROBE,
    ST_RDREQ,
    ST_RDWAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/slave_in_port_serial_shift_in.sv
// LSB-first serial-to-parallel shifter with a bit counter. value_next is the
// word as it stands after the current edge, so a full word is usable on the edge
// that shifts in its last bit. WIDTH must be at least 2.
module slave_in_port_serial_shift_in #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] value_next,
  output logic             last,
  output logic             full
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] value;
  logic [CW-1:0]    count;

  assign value_next = shift_en ? {bit_in, value[WIDTH-1:1]} : value;
  assign last       = (count == CW'(WIDTH - 1));
  assign full       = (count == CW'(WIDTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
      count <= '0;
    end else if (clear) begin
      value <= '0;
      count <= '0;
    end else if (shift_en) begin
      value <= value_next;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/slave_in_port.sv
// Slave-side receiver for the serial system bus: deserialises address, burst and
// write data, strobes local memory per beat, and hands reads to the read-return block.
module slave_in_port
  import slave_in_port_pkg::*;
#(
  parameter logic [1:0] SLAVE_ID    = SEL_SLAVE0,
  parameter int         ADDR_WIDTH  = BUS_ADDR_WIDTH,
  parameter int         DATA_WIDTH  = BUS_DATA_WIDTH,
  parameter int         BURST_WIDTH = BUS_BURST_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             slave_select,
  input  logic                   master_valid,
  input  logic                   write_en,
  input  logic                   read_en,
  input  logic                   rx_address,
  input  logic                   rx_burst_number,
  input  logic                   rx_data,
  input  logic                   read_done,
  output logic                   slave_ready,
  output logic                   rx_done,
  output logic                   mem_wr_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  output logic                   read_req,
  output logic [ADDR_WIDTH-1:0]  read_addr,
  output logic [BURST_WIDTH-1:0] read_burst
);

  state_t                 state;
  logic                   dir_write;
  logic [BURST_WIDTH-1:0] beat;
  logic [ADDR_WIDTH-1:0]  addr_lat;
  logic [BURST_WIDTH-1:0] burst_lat;

  logic                   accept;
  logic                   addr_en, burst_en, data_en;
  logic                   addr_last, addr_full, burst_last, burst_full, data_last, data_full;
  logic [ADDR_WIDTH-1:0]  addr_next;
  logic [BURST_WIDTH-1:0] burst_next;
  logic [DATA_WIDTH-1:0]  data_next;
  logic                   hdr_done, data_done;

  assign accept   = master_valid & slave_ready;
  // The narrower header field stops shifting once full while the wider one finishes.
  assign addr_en  = accept & (state == ST_ADDR) & ~addr_full;
  assign burst_en = accept & (state == ST_ADDR) & ~burst_full;
  assign data_en  = accept & (state == ST_DATA) & ~data_full;

  assign hdr_done  = (state == ST_ADDR) & accept &
                     (addr_full | (addr_en & addr_last)) &
                     (burst_full | (burst_en & burst_last));
  assign data_done = data_en & data_last;

  slave_in_port_serial_shift_in #(.WIDTH(ADDR_WIDTH)) u_addr_shift (
    .clk(clk), .reset(reset), .clear(state == ST_IDLE), .shift_en(addr_en),
    .bit_in(rx_address), .value_next(addr_next), .last(addr_last), .full(addr_full)
  );

  slave_in_port_serial_shift_in #(.WIDTH(BURST_WIDTH)) u_burst_shift (
    .clk(clk), .reset(reset), .clear(state == ST_IDLE), .shift_en(burst_en),
    .bit_in(rx_burst_number), .value_next(burst_next), .last(burst_last), .full(burst_full)
  );

  slave_in_port_serial_shift_in #(.WIDTH(DATA_WIDTH)) u_data_shift (
    .clk(clk), .reset(reset), .clear((state == ST_IDLE) | (state == ST_WSTROBE)),
    .shift_en(data_en), .bit_in(rx_data), .value_next(data_next), .last(data_last),
    .full(data_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      dir_write   <= 1'b0;
      beat        <= '0;
      addr_lat    <= '0;
      burst_lat   <= '0;
      slave_ready <= 1'b0;
      rx_done     <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      read_req    <= 1'b0;
      read_addr   <= '0;
      read_burst  <= '0;
    end else begin
      mem_wr_en <= 1'b0;
      read_req  <= 1'b0;
      rx_done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          beat <= '0;
          if (master_valid && (slave_select == SLAVE_ID) && (write_en ^ read_en)) begin
            state       <= ST_ADDR;
            dir_write   <= write_en;
            slave_ready <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (hdr_done) begin
            addr_lat  <= addr_next;
            burst_lat <= burst_next;
            if (dir_write) begin
              state <= ST_DATA;
            end else begin
              state       <= ST_RDREQ;
              slave_ready <= 1'b0;
              read_req    <= 1'b1;
              read_addr   <= addr_next;
              read_burst  <= burst_next;
            end
          end
        end
        ST_DATA: begin
          if (data_done) begin
            state       <= ST_WSTROBE;
            slave_ready <= 1'b0;
            mem_wr_en   <= 1'b1;
            mem_addr    <= addr_lat + ADDR_WIDTH'(beat);
            mem_wdata   <= data_next;
          end
        end
        ST_WSTROBE: begin
          if (beat == burst_lat) begin
            state   <= ST_DONE;
            rx_done <= 1'b1;
          end else begin
            beat        <= beat + 1'b1;
            state       <= ST_DATA;
            slave_ready <= 1'b1;
          end
        end
        ST_RDREQ: state <= ST_RDWAIT;
        ST_RDWAIT: begin
          if (read_done) begin
            state   <= ST_DONE;
            rx_done <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
